// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the demux dispatch controller: channel count,
// select width, FSM state encoding and round-robin helper.
package demux_ctrl_pkg;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Next round-robin channel; the SEL_W-bit add wraps 3 back to 0.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux_valid_1x4.sv
// One-hot valid steering: drives exactly bit `sel` of `onehot` when `valid` is set.
module demux_valid_1x4
  import demux_ctrl_pkg::*;
(
  input  logic             valid,
  input  logic [SEL_W-1:0] sel,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (valid) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-word dispatcher: accepts one word in IDLE, holds it on one of four
// channels until that channel is ready or the wait limit expires.
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   fixed_sel,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wmode_q, wmode_d;
  logic                pulse_q, pulse_d;
  logic [CNT_W-1:0]    cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    wmode_d = wmode_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_HOLD;
          data_d  = in_data;
          sel_d   = mode ? rr_q : fixed_sel;
          wmode_d = mode;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (out_ready[sel_q]) begin
          state_d = ST_IDLE;
          if (wmode_q) rr_d = next_sel(sel_q);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d = ST_IDLE;
            pulse_d = 1'b1;
            if (wmode_q) rr_d = next_sel(sel_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      wmode_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wmode_q <= wmode_d;
      pulse_q <= pulse_d;
    end
  end

  demux_valid_1x4 u_valid (
    .valid  (state_q == ST_HOLD),
    .sel    (sel_q),
    .onehot (out_valid)
  );

  assign in_ready      = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_HOLD);
  assign sel           = sel_q;
  assign out_data      = data_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_demux_dispatch_ctrl;

  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0;
  logic [1:0]    fixed_sel = '0;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = '0;
  logic          busy;
  logic          timeout_pulse;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mode          (mode),
    .fixed_sel     (fixed_sel),
    .sel           (sel),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: is a word held, which word, where, how long it has waited.
  bit m_known = 0;
  bit m_hold, m_wmode, m_pulse;
  int m_data, m_sel, m_wait, m_rr;
  int deliv[$];
  int pulses;

  task automatic cycle(input bit r, input bit iv, input logic [7:0] d,
                       input bit md, input logic [1:0] fs, input logic [3:0] ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; mode = md; fixed_sel = fs; out_ready = ordy;
    #1;
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("busy", 32'(busy), 32'(m_hold));
      chk("out_valid", 32'(out_valid), m_hold ? (32'd1 << m_sel) : 32'd0);
      chk("sel", 32'(sel), 32'(m_sel));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    end
    if (!r && (out_valid & ordy) != 4'b0) deliv.push_back(int'(sel));
    if (timeout_pulse) pulses++;
    if (r) begin
      m_known = 1; m_hold = 0; m_data = 0; m_sel = 0; m_wait = 0;
      m_rr = 0; m_pulse = 0; m_wmode = 0;
    end else if (!m_hold) begin
      m_pulse = 0;
      if (iv) begin
        m_hold = 1; m_data = int'(d); m_sel = md ? m_rr : int'(fs);
        m_wmode = md; m_wait = 0;
      end
    end else begin
      m_pulse = 0;
      if (ordy[m_sel]) begin
        m_hold = 0;
        if (m_wmode) m_rr = (m_sel + 1) % 4;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_hold = 0; m_pulse = 1;
          if (m_wmode) m_rr = (m_sel + 1) % 4;
        end
      end
    end
  endtask

  initial begin
    int exp38[5];
    int n39;
    exp38 = '{0, 1, 2, 3, 0};

    cycle(1, 0, 8'h00, 0, 2'd0, 4'h0);
    cycle(1, 0, 8'h00, 0, 2'd0, 4'h0);
    cycle(0, 0, 8'h00, 0, 2'd0, 4'h0);

    // Round-robin burst, one word per two cycles.
    deliv.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 8'(8'h11 * (i + 1)), 1, 2'd0, 4'hF);
      cycle(0, 0, 8'h00, 1, 2'd0, 4'hF);
    end
    chk("rr_count", 32'(deliv.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < deliv.size()) chk("rr_order", 32'(deliv[i]), 32'(exp38[i]));

    // Fixed channel 2, ready held low 3 cycles; other ready bits ignored.
    n39 = 0;
    cycle(0, 1, 8'hA5, 0, 2'd2, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 8'h00, 0, 2'd2, 4'b1011);
      n39 += (out_valid == 4'b0100) ? 1 : 0;
    end
    cycle(0, 0, 8'h00, 0, 2'd2, 4'b0100);
    n39 += (out_valid == 4'b0100) ? 1 : 0;
    cycle(0, 0, 8'h00, 0, 2'd0, 4'h0);
    chk("hold_cycles", 32'(n39), 32'd4);

    // Timeout drop in round-robin mode (pointer currently 1).
    pulses = 0;
    cycle(0, 1, 8'h3C, 1, 2'd0, 4'h0);
    for (int i = 0; i < TO + 2; i++) cycle(0, 0, 8'h00, 1, 2'd0, 4'h0);
    chk("single_pulse", 32'(pulses), 32'd1);
    deliv.delete();
    cycle(0, 1, 8'h77, 1, 2'd0, 4'hF);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'hF);
    chk("rr_after_drop", deliv.size() > 0 ? 32'(deliv[0]) : 32'hDEAD, 32'd2);

    // Completion on the last permitted cycle wins over timeout.
    pulses = 0; deliv.delete();
    cycle(0, 1, 8'h5A, 1, 2'd0, 4'h0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 8'h00, 1, 2'd0, 4'h0);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'hF);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'h0);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'h0);
    chk("late_complete_pulse", 32'(pulses), 32'd0);
    chk("late_complete_chan", deliv.size() > 0 ? 32'(deliv[0]) : 32'hDEAD, 32'd3);

    // Reset during HOLD discards the word and the pointer.
    pulses = 0; deliv.delete();
    cycle(0, 1, 8'h99, 1, 2'd0, 4'h0);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'h0);
    cycle(1, 0, 8'h00, 1, 2'd0, 4'h0);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'h0);
    cycle(0, 1, 8'h42, 1, 2'd0, 4'hF);
    cycle(0, 0, 8'h00, 1, 2'd0, 4'hF);
    chk("rst_no_pulse", 32'(pulses), 32'd0);
    chk("rst_rr_zero", deliv.size() > 0 ? 32'(deliv[0]) : 32'hDEAD, 32'd0);

    // fixed_sel/mode changes mid-flight do not move the word.
    deliv.delete();
    cycle(0, 1, 8'hC3, 0, 2'd2, 4'h0);
    cycle(0, 0, 8'h00, 1, 2'd1, 4'h0);
    cycle(0, 0, 8'h00, 1, 2'd1, 4'b0110);
    cycle(0, 0, 8'h00, 0, 2'd1, 4'h0);
    chk("inflight_chan", deliv.size() > 0 ? 32'(deliv[0]) : 32'hDEAD, 32'd2);

    // Random traffic; ready is often idle so timeouts occur too.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom),
            1'($urandom),
            2'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of the data word.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles a word waits for its destination before being dropped.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_data  input  DATA_W  word to dispatch.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 mode  input  1  0 = fixed destination, 1 = round-robin.
REQ-010 fixed_sel  input  2  destination used when mode=0.
REQ-011 sel  output  2  destination channel currently driven.
REQ-012 out_data  output  DATA_W  held word, broadcast to all channels.
REQ-013 out_valid  output  4  one-hot valid, only bit sel may be set.
REQ-014 out_ready  input  4  per-channel downstream ready.
REQ-015 busy  output  1  high while in HOLD.
REQ-016 timeout_pulse  output  1  one-cycle pulse when a word is dropped.

Function
REQ-017 FSM states SHALL be exactly IDLE and HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-019 In IDLE with in_valid=1, the block SHALL latch in_data, latch the destination, clear the wait counter and enter HOLD on the next edge.
REQ-020 Destination selection: mode=0 -> fixed_sel sampled at acceptance; mode=1 -> round-robin pointer rr_ptr.
REQ-021 HOLD: in_ready=0, busy=1, out_valid[sel]=1, all other out_valid bits 0, out_data = latched word.
REQ-022 Latency SHALL be one cycle: out_valid asserts in the cycle after acceptance.
REQ-023 A transfer completes in a HOLD cycle where out_ready[sel]=1; the FSM SHALL then return to IDLE.
REQ-024 The ready bits of non-selected channels SHALL be ignored.
REQ-025 Sustained throughput SHALL be one word per two cycles; no bypass from IDLE to HOLD->HOLD.
REQ-026 The wait counter SHALL increment on each HOLD cycle without completion.
REQ-027 If the counter reaches TIMEOUT with out_ready[sel]=0, the block SHALL drop the word, pulse timeout_pulse for one cycle and return to IDLE.
REQ-028 If completion and timeout occur in the same cycle, completion SHALL win and no pulse SHALL occur.
REQ-029 rr_ptr SHALL advance to sel+1 (mod 4, 3 wraps to 0) on completion or drop, only when mode=1 for that word.
REQ-030 In mode=0, rr_ptr SHALL hold its value.
REQ-031 Changes to mode or fixed_sel during HOLD SHALL NOT affect the word in flight.
REQ-032 The sel output SHALL hold its last value while in IDLE.

Reset
REQ-033 On rst, state=IDLE, rr_ptr=0, sel=0, counter=0, held data=0, out_valid=0, timeout_pulse=0.
REQ-034 rst asserted during HOLD SHALL discard the word with no pulse, and in_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-035 A shared package demux_ctrl_pkg SHALL hold the state encodings, NUM_OUT=4 and SEL_W=2.
REQ-036 The one-hot valid steering SHALL be a sub-module, demux_valid_1x4 (inputs: valid, sel; output: 4-bit one-hot).
REQ-037 The FSM, rr_ptr, wait counter and data register SHALL live in demux_dispatch_ctrl.

Verification
REQ-038 mode=1, out_ready=4'b1111, 5 words 0x11..0x55 -> delivered to channels 0,1,2,3,0; one word per two cycles.
REQ-039 mode=0, fixed_sel=2, word 0xA5, out_ready[2] low for 3 cycles -> out_valid=4'b0100 held for 4 cycles, then IDLE; no pulse.
REQ-040 out_ready=0, TIMEOUT=15, one word -> drop after 15 HOLD cycles with a single timeout_pulse; rr_ptr advances in mode=1.
REQ-041 Completion on the TIMEOUT cycle -> word delivered, timeout_pulse stays 0.
REQ-042 rst asserted in HOLD -> out_valid=0 the next cycle, rr_ptr=0, in_ready=1 after release.
REQ-043 fixed_sel toggled 2->1 during HOLD -> in-flight word stays on channel 2.
